// File: rtl/if_stage_pkg.sv
// Shared constants and types for the fetch stage: reset/bubble values, predicted opcodes,
// IF/ID bundle layout and the b/bl offset decode.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0340_0000;

  localparam logic [5:0] OP_B  = 6'h14;
  localparam logic [5:0] OP_BL = 6'h15;

  localparam int unsigned ZIP_W        = 65;
  localparam int unsigned ZIP_PRED_BIT = 64;
  localparam int unsigned ZIP_INST_LSB = 32;
  localparam int unsigned ZIP_PC_LSB   = 0;

  // Field order matches {predict[64], inst[63:32], pc[31:0]}.
  typedef struct packed {
    logic        predict;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_zip_t;

  // b/bl carry a 26-bit word offset split as offs[25:16]=inst[9:0], offs[15:0]=inst[25:10].
  function automatic logic [31:0] branch_offset(input logic [31:0] inst);
    return {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  endfunction

endpackage

// File: rtl/if_predecoder.sv
// Static predictor: b/bl in a valid fetch slot are predicted taken to pc + offset.
module if_predecoder
  import if_stage_pkg::*;
#(
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o
);

  logic [5:0] opcode;

  assign opcode        = inst_i[31:26];
  assign pred_taken_o  = PREDICT_EN && valid_i && ((opcode == OP_B) || (opcode == OP_BL));
  assign pred_target_o = pc_i + branch_offset(inst_i);

endmodule

// File: rtl/if_stage.sv
// Fetch stage with IF/ID register: drives a 1-cycle inst SRAM, buffers the returned
// instruction across decode stalls, and applies decode redirects ahead of static prediction.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF,
  parameter bit          PREDICT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_allowin,
  input  logic             flush,
  input  logic [31:0]      pc_real,
  output logic             inst_sram_en,
  output logic [3:0]       inst_sram_we,
  output logic [31:0]      inst_sram_addr,
  output logic [31:0]      inst_sram_wdata,
  input  logic [31:0]      inst_sram_rdata,
  output logic [ZIP_W-1:0] IF_to_ID_zip
);

  localparam if_id_zip_t BUBBLE = '{predict: 1'b0, inst: NOP_INST, pc: 32'h0};

  logic [31:0] pc_f_q, pc_f_d;
  logic        valid_f_q, valid_f_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        buf_valid_q, buf_valid_d;
  if_id_zip_t  zip_q, zip_d;

  logic [31:0] inst_f;
  logic        f_allowin;
  logic        f_advance;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] nextpc;

  // The SRAM drops rdata once the request strobe goes low, so a stalled F reads the buffer.
  assign inst_f    = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign f_allowin = ~valid_f_q | ID_allowin;
  assign f_advance = f_allowin | flush;

  if_predecoder #(.PREDICT_EN(PREDICT_EN)) u_predecoder (
    .valid_i       (valid_f_q),
    .inst_i        (inst_f),
    .pc_i          (pc_f_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target)
  );

  assign nextpc = flush      ? pc_real     :
                  pred_taken ? pred_target :
                               pc_f_q + 32'd4;

  assign inst_sram_en    = ~rst & f_advance;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign IF_to_ID_zip    = zip_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    pc_f_d      = pc_f_q;
    valid_f_d   = valid_f_q;
    inst_buf_d  = inst_buf_q;
    buf_valid_d = buf_valid_q;
    zip_d       = zip_q;

    if (f_advance) begin
      pc_f_d      = nextpc;
      valid_f_d   = 1'b1;
      buf_valid_d = 1'b0;
    end else if (!buf_valid_q) begin
      inst_buf_d  = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end

    if (ID_allowin) begin
      zip_d = (valid_f_q && !flush) ? '{predict: pred_taken, inst: inst_f, pc: pc_f_q} : BUBBLE;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q      <= RESET_PC - 32'd4;
      valid_f_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      zip_q       <= BUBBLE;
    end else begin
      pc_f_q      <= pc_f_d;
      valid_f_q   <= valid_f_d;
      buf_valid_q <= buf_valid_d;
      zip_q       <= zip_d;
    end
  end

  // NOTE: the instruction buffer is data-only and qualified by buf_valid_q, so it has no reset.
  always_ff @(posedge clk) begin
    inst_buf_q <= inst_buf_d;
  end

endmodule
